// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display scheduler; no logic, no latency.
package disp_pkg;

  localparam int N_SRC            = 4;
  localparam int DWELL_CYCLES_DEF = 50_000_000;
  localparam int LAMP_CYCLES_DEF  = 25_000_000;

  typedef enum logic [1:0] {
    ST_LAMP   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SHOW   = 2'd2,
    ST_MANUAL = 2'd3
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick among 4 requesters, searching upward from start with wrap.
// Zero latency; no flow control, found=0 when no bit of req is set.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  // Walk the search order backwards so the nearest requester to start wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = 3; k >= 0; k--) begin
      if (req[start + 2'(k)]) begin
        found = 1'b1;
        idx   = start + 2'(k);
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 32-bit display word among 4 sources: lamp test, round-robin dwell, manual, freeze.
// All outputs registered (1-cycle latency); freeze stalls the dwell counter and the shown word.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int LAMP_CYCLES  = LAMP_CYCLES_DEF,
  parameter int CW           = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      req,
  input  logic [32*N_SRC-1:0]   src_data,
  input  logic                  manual_en,
  input  logic [1:0]            manual_sel,
  input  logic                  freeze,
  input  logic                  lamp_req,
  output logic [31:0]           disp_data,
  output logic                  disp_all0,
  output logic [1:0]            src_sel,
  output logic [N_SRC-1:0]      grant,
  output logic                  busy
);

  localparam logic [CW-1:0] LAMP_LAST  = CW'(LAMP_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  state_e      st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic        all0_q, all0_d;
  logic [3:0]  grant_q, grant_d;
  logic        busy_q, busy_d;

  logic        rr_found;
  logic [1:0]  rr_idx;
  logic [31:0] cur_word;

  assign cur_word = src_data[32*sel_q +: 32];

  rr_pick4 u_rr (
    .req   (req),
    .start (sel_q + 2'd1),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    all0_d  = all0_q;
    grant_d = 4'b0000;

    if (lamp_req) begin
      st_d   = ST_LAMP;
      cnt_d  = '0;
      all0_d = 1'b1;
      data_d = '0;
    end else begin
      case (st_q)
        ST_LAMP: begin
          data_d = '0;
          all0_d = 1'b1;
          if (cnt_q == LAMP_LAST) begin
            cnt_d  = '0;
            all0_d = 1'b0;
            if (manual_en) begin
              st_d  = ST_MANUAL;
              sel_d = manual_sel;
            end else if (rr_found) begin
              st_d    = ST_SHOW;
              sel_d   = rr_idx;
              grant_d = onehot4(rr_idx);
            end else begin
              st_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_IDLE: begin
          if (manual_en) begin
            st_d  = ST_MANUAL;
            sel_d = manual_sel;
            cnt_d = '0;
          end else if (!freeze && rr_found) begin
            st_d    = ST_SHOW;
            sel_d   = rr_idx;
            grant_d = onehot4(rr_idx);
            cnt_d   = '0;
          end
        end

        ST_SHOW: begin
          if (!freeze) data_d = cur_word;
          if (manual_en) begin
            st_d  = ST_MANUAL;
            sel_d = manual_sel;
            cnt_d = '0;
          end else if (!freeze) begin
            if (cnt_q == DWELL_LAST) begin
              cnt_d = '0;
              // The search wraps back to the current source last, so idx==sel means "stay".
              if (!rr_found) begin
                st_d = ST_IDLE;
              end else if (rr_idx != sel_q) begin
                sel_d   = rr_idx;
                grant_d = onehot4(rr_idx);
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        ST_MANUAL: begin
          if (!freeze) data_d = cur_word;
          cnt_d = '0;
          if (manual_en) begin
            sel_d = manual_sel;
          end else begin
            st_d    = ST_SHOW;
            grant_d = onehot4(sel_q);
          end
        end

        default: ;
      endcase
    end

    busy_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_LAMP;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      all0_q  <= 1'b1;
      grant_q <= 4'b0000;
      busy_q  <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      all0_q  <= all0_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign disp_data = data_q;
  assign disp_all0 = all0_q;
  assign src_sel   = sel_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule
